// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    // A set top bit already exceeds any WIDTH-bit divisor; otherwise diff's top bit is the borrow.
    q_o     = shifted[WIDTH] | ~diff[WIDTH];
    rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with valid/ready operand and result handshakes.
// Optional DIV_ZERO_FLAG_EN: zero divisor short-circuits to DONE and raises div_zero.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
`ifdef DIV_ZERO_FLAG_EN
  logic             dz_q, dz_d;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (acc_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef DIV_ZERO_FLAG_EN
    dz_d        = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = BUSY;
          cnt_d      = CW'(WIDTH);
          acc_d      = dividend;
          rem_d      = '0;
          dsr_d      = divisor;
          in_ready_d = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
          dz_d       = 1'b0;
          if (divisor == '0) begin
            state_d     = DONE;
            cnt_d       = '0;
            acc_d       = '1;
            rem_d       = dividend;
            dz_d        = 1'b1;
            out_valid_d = 1'b1;
          end
`endif
        end
      end
      BUSY: begin
        acc_d = {acc_q[WIDTH-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef DIV_ZERO_FLAG_EN
      dz_q        <= dz_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = acc_q;
  assign remainder = rem_q;
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero  = dz_q;
`else
  assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed + randomized bench for seq_divider (WIDTH=8) against an arithmetic / and % model.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef DIV_ZERO_FLAG_EN
  localparam bit FLAG_EN = 1'b1;
`else
  localparam bit FLAG_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, with the zero-divisor convention.
  task automatic model(input int a, input int b, output int q, output int r, output int dz, output int lat);
    if (b == 0) begin
      q   = (1 << W) - 1;
      r   = a;
      dz  = FLAG_EN ? 1 : 0;
      lat = FLAG_EN ? 0 : W;
    end else begin
      q   = a / b;
      r   = a % b;
      dz  = 0;
      lat = W;
    end
  endtask

  // Returns the cycle stamp of the accepting edge.
  task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b, output int e);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    for (int i = 0; i < 64 && !in_ready; i++) @(negedge clk);
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    e        = cyc;
    in_valid = 1'b0;
  endtask

  // Latency is reported as the number of edges after the accept edge at which out_valid rose.
  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int e);
    int q, r, dz, lat;
    model(int'(a), int'(b), q, r, dz, lat);
    @(negedge clk);
    for (int i = 0; i < 64 && !out_valid; i++) @(negedge clk);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_latency"}, cyc - e, lat);
    chk({tag, "_quot"}, {24'd0, quotient}, q);
    chk({tag, "_rem"}, {24'd0, remainder}, r);
    chk({tag, "_dz"}, {31'd0, div_zero}, dz);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int e, e1, e2, e3, q, r, dz, lat;
    logic [W-1:0] a, b;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quot", {24'd0, quotient}, 32'd0);
    chk("rst_rem", {24'd0, remainder}, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    rst_n = 1'b1;

    // 200/7 then hold the result under backpressure with a competing in_valid.
    do_accept(8'd200, 8'd7, e);
    check_result("d200_7", 8'd200, 8'd7, e);
    in_valid = 1'b1;
    dividend = 8'd3;
    divisor  = 8'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_quot", {24'd0, quotient}, 32'd28);
      chk("bp_rem", {24'd0, remainder}, 32'd4);
    end
    in_valid = 1'b0;
    take();
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

    // Back-to-back with out_ready held high: initiation interval W+2.
    out_ready = 1'b1;
    do_accept(8'd5, 8'd9, e1);
    check_result("d5_9", 8'd5, 8'd9, e1);
    do_accept(8'd255, 8'd1, e2);
    check_result("d255_1", 8'd255, 8'd1, e2);
    do_accept(8'd255, 8'd255, e3);
    check_result("d255_255", 8'd255, 8'd255, e3);
    chk("interval_1", e2 - e1, W + 2);
    chk("interval_2", e3 - e2, W + 2);
    @(negedge clk);
    out_ready = 1'b0;

    // Zero divisor.
    do_accept(8'd100, 8'd0, e);
    check_result("d100_0", 8'd100, 8'd0, e);
    take();

    // Asynchronous reset in the middle of BUSY.
    do_accept(8'd200, 8'd7, e);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_quot", {24'd0, quotient}, 32'd0);
    chk("midrst_rem", {24'd0, remainder}, 32'd0);
    chk("midrst_dz", {31'd0, div_zero}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    do_accept(8'd9, 8'd2, e);
    check_result("d9_2", 8'd9, 8'd2, e);
    take();

    // Randomized operands, gaps and result backpressure.
    for (int n = 0; n < 1000; n++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      model(int'(a), int'(b), q, r, dz, lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_accept(a, b, e);
      out_ready = 1'($urandom_range(0, 1));
      check_result("rnd", a, b, e);
      if (!out_ready) begin
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
          @(negedge clk);
          chk("rnd_hold_quot", {24'd0, quotient}, q);
          chk("rnd_hold_rem", {24'd0, remainder}, r);
        end
      end
      take();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
